// File: rtl/capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : capture_pkg                                                  |
// | Description : Shared constants and the capture state type for the sample   |
// |               capture path (ADC stream -> trigger -> displayed frame).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package capture_pkg;

    localparam int N_SAMPLES        = 256;    // samples per published frame
    localparam int DATA_W           = 12;     // ADC sample width
    localparam int DEF_AUTO_TIMEOUT = 65535;  // kept samples before a forced trigger
    localparam int TCNT_W           = 16;     // saturating timeout counter width
    localparam int DECIM_W          = 4;      // decimation ratio field width

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        DONE      = 3'd4
    } capture_state_t;

endpackage
`default_nettype wire

// File: rtl/trigger_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trigger_detect                                               |
// | Description : Level-crossing detector with auto-trigger timeout. Holds the |
// |               previous kept sample and flags a rising/falling crossing or  |
// |               an expired wait as single-cycle pulses.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trigger_detect
    import capture_pkg::*;
#(
    parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_sample_en,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_level,
    input  logic              i_falling,
    output logic              o_hit,
    output logic              o_auto
);

    localparam logic [TCNT_W-1:0] C_TIMEOUT = TCNT_W'(AUTO_TIMEOUT);

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;
    logic [TCNT_W-1:0] r_tcnt;
    logic              w_rise;
    logic              w_fall;
    logic              w_edge;

    // Edge compare against the previous kept sample; a crossing beats the timeout
    always_comb begin
        w_rise = (r_prev < i_level) && (i_sample >= i_level);
        w_fall = (r_prev >= i_level) && (i_sample < i_level);
        w_edge = i_falling ? w_fall : w_rise;
        o_hit  = i_sample_en && r_prev_vld && w_edge;
        o_auto = i_sample_en && r_prev_vld && !w_edge && (r_tcnt == C_TIMEOUT);
    end

    // Previous-sample history and saturating wait counter, cleared on every arm
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_tcnt     <= '0;
        end else if (i_clear) begin
            r_prev_vld <= 1'b0;
            r_tcnt     <= '0;
        end else if (i_sample_en) begin
            r_prev     <= i_sample;
            r_prev_vld <= 1'b1;
            if (!o_hit && !o_auto && (r_tcnt != '1)) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_capture                                               |
// | Description : Decimates the ADC stream, waits for a level trigger (or auto |
// |               timeout), fills a shadow frame and publishes it to the       |
// |               display array only on a vblank rising edge (tear-free).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sample_capture
    import capture_pkg::*;
#(
    parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               adc_valid,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               trig_falling,
    input  logic [DECIM_W-1:0] decim,
    input  logic               run,
    input  logic               single,
    input  logic               vblnk,
    output logic [DATA_W-1:0]  data_display [0:N_SAMPLES-1],
    output logic               busy,
    output logic               triggered
);

    localparam int               IDX_W      = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_SAMPLES - 1);

    capture_state_t     r_state;
    capture_state_t     w_next;
    logic [DECIM_W-1:0] r_decim_q;
    logic [DECIM_W-1:0] r_dcnt;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [DATA_W-1:0]  r_shadow [0:N_SAMPLES-1];
    logic               r_trig_q;
    logic               r_vblnk_d;

    logic w_counting;
    logic w_kept;
    logic w_vblnk_rise;
    logic w_hit;
    logic w_auto;
    logic w_start;
    logic w_latch_decim;
    logic w_arm_clear;
    logic w_td_en;
    logic w_cap_write;
    logic w_publish;

    // Samples only count while hunting for a trigger or filling the frame
    always_comb begin
        w_counting   = adc_valid && ((r_state == WAIT_TRIG) || (r_state == CAPTURE));
        w_kept       = w_counting && (r_dcnt == r_decim_q);
        w_vblnk_rise = vblnk && !r_vblnk_d;
        w_start      = w_hit || w_auto;
    end

    trigger_detect #(
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) u_trigger_detect (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_arm_clear),
        .i_sample_en (w_td_en),
        .i_sample    (adc_data),
        .i_level     (trig_level),
        .i_falling   (trig_falling),
        .o_hit       (w_hit),
        .o_auto      (w_auto)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; run is sampled at publish time to choose re-arm or stop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (run || single) w_next = ARMED;
            ARMED:     w_next = WAIT_TRIG;
            WAIT_TRIG: if (w_start) w_next = CAPTURE;
            CAPTURE:   if (w_kept && (r_wr_idx == C_LAST_IDX)) w_next = DONE;
            DONE:      if (w_vblnk_rise) w_next = run ? ARMED : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and per-state datapath strobes
    always_comb begin
        busy          = 1'b0;
        w_latch_decim = 1'b0;
        w_arm_clear   = 1'b0;
        w_td_en       = 1'b0;
        w_cap_write   = 1'b0;
        w_publish     = 1'b0;
        case (r_state)
            IDLE:      w_latch_decim = run || single;
            ARMED: begin
                busy        = 1'b1;
                w_arm_clear = 1'b1;
            end
            WAIT_TRIG: begin
                busy    = 1'b1;
                w_td_en = w_kept;
            end
            CAPTURE: begin
                busy        = 1'b1;
                w_cap_write = w_kept;
            end
            DONE: begin
                busy      = 1'b1;
                w_publish = w_vblnk_rise;
            end
            default: busy = 1'b0;
        endcase
    end

    // Decimator: keep one of every decim_q+1 valid samples, restarted on each arm
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dcnt <= '0;
        end else if (w_arm_clear) begin
            r_dcnt <= '0;
        end else if (w_counting) begin
            r_dcnt <= w_kept ? '0 : (r_dcnt + 1'b1);
        end
    end

    // Delayed vblank for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vblnk_d <= 1'b0;
        end else begin
            r_vblnk_d <= vblnk;
        end
    end

    // Shadow frame fill: trigger sample lands in slot 0, then sequential writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_decim_q <= '0;
            r_wr_idx  <= '0;
            r_trig_q  <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_latch_decim) begin
                r_decim_q <= decim;
            end
            if (w_arm_clear) begin
                r_wr_idx <= '0;
            end else if (w_start) begin
                r_shadow[0] <= adc_data;
                r_wr_idx    <= IDX_W'(1);
                r_trig_q    <= w_hit;
            end else if (w_cap_write) begin
                r_shadow[r_wr_idx] <= adc_data;
                r_wr_idx           <= r_wr_idx + 1'b1;
            end
        end
    end

    // Publish the complete frame in one cycle, only at a vblank rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            triggered <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                data_display[i] <= '0;
            end
        end else if (w_publish) begin
            triggered <= r_trig_q;
            for (int i = 0; i < N_SAMPLES; i++) begin
                data_display[i] <= r_shadow[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sample_capture                                            |
// | Description : Self-checking bench for sample_capture with a frame-level    |
// |               reference model and randomized ADC / control stimulus.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sample_capture;
    import capture_pkg::*;

    localparam int AUTO_TO = 300;
    localparam int P_IDLE  = 0;
    localparam int P_ARM   = 1;
    localparam int P_WAIT  = 2;
    localparam int P_CAP   = 3;
    localparam int P_DONE  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [DATA_W-1:0]  adc_data = '0;
    logic               adc_valid = 1'b0;
    logic [DATA_W-1:0]  trig_level = '0;
    logic               trig_falling = 1'b0;
    logic [DECIM_W-1:0] decim = '0;
    logic               run = 1'b0;
    logic               single = 1'b0;
    logic               vblnk = 1'b0;
    logic [DATA_W-1:0]  data_display [0:N_SAMPLES-1];
    logic               busy;
    logic               triggered;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // stimulus generator controls
    int gen_mode = 0;   // 0 none, 1 ramp, 2 constant, 3 random
    int ramp     = 0;
    int step     = 0;
    int cval     = 0;
    int vprob    = 100;
    bit vb_auto  = 1'b0;
    int cyc_n    = 0;

    // reference model state
    int                m_ph   = P_IDLE;
    int                m_dq   = 0;
    int                m_dcnt = 0;
    int                m_tcnt = 0;
    logic [DATA_W-1:0] m_prev = '0;
    bit                m_pv   = 1'b0;
    bit                m_tq   = 1'b0;
    bit                m_trig = 1'b0;
    bit                m_vd   = 1'b0;
    bit                m_kept = 1'b0;
    bit                m_lvl  = 1'b0;
    logic [DATA_W-1:0] m_frame [$];
    logic [DATA_W-1:0] m_disp [0:N_SAMPLES-1];

    sample_capture #(
        .AUTO_TIMEOUT (AUTO_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .decim        (decim),
        .run          (run),
        .single       (single),
        .vblnk        (vblnk),
        .data_display (data_display),
        .busy         (busy),
        .triggered    (triggered)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ph(input int ph, input int budget, input string nm);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_ph != ph) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, phase %0d expected %0d", nm, n, m_ph, ph);
        end
    endtask

    task automatic pulse_single();
        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
    endtask

    task automatic vblank_edge();
        vblnk = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
    endtask

    // ADC sample source and optional periodic vblank
    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (gen_mode == 0) begin
            adc_valid = 1'b0;
        end else begin
            adc_valid = (int'($urandom_range(99)) < vprob);
            if (adc_valid) begin
                case (gen_mode)
                    1: begin
                        adc_data = ramp[DATA_W-1:0];
                        ramp     = (ramp + step) & 4095;
                    end
                    2:       adc_data = cval[DATA_W-1:0];
                    default: adc_data = DATA_W'($urandom_range(4095));
                endcase
            end
        end
        if (vb_auto) vblnk = ((cyc_n % 97) < 6);
    end

    // Reference model: frame built as a queue of kept samples after the trigger
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = P_IDLE; m_dq = 0; m_dcnt = 0; m_tcnt = 0; m_prev = '0;
            m_pv = 1'b0; m_tq = 1'b0; m_trig = 1'b0; m_vd = 1'b0;
            m_frame.delete();
            for (int i = 0; i < N_SAMPLES; i++) m_disp[i] = '0;
        end else begin
            m_kept = 1'b0;
            if (adc_valid && (m_ph == P_WAIT || m_ph == P_CAP)) begin
                if (m_dcnt == m_dq) begin
                    m_kept = 1'b1;
                    m_dcnt = 0;
                end else begin
                    m_dcnt++;
                end
            end
            case (m_ph)
                P_IDLE: if (run || single) begin
                    m_dq = int'(decim);
                    m_ph = P_ARM;
                end
                P_ARM: begin
                    m_pv = 1'b0; m_tcnt = 0; m_dcnt = 0;
                    m_frame.delete();
                    m_ph = P_WAIT;
                end
                P_WAIT: if (m_kept) begin
                    if (m_pv) begin
                        m_lvl = trig_falling ? (m_prev >= trig_level && adc_data < trig_level)
                                             : (m_prev < trig_level && adc_data >= trig_level);
                        if (m_lvl || m_tcnt == AUTO_TO) begin
                            m_tq = m_lvl;
                            m_frame.push_back(adc_data);
                            m_ph = P_CAP;
                        end else if (m_tcnt < 65535) begin
                            m_tcnt++;
                        end
                    end else begin
                        m_tcnt++;
                    end
                    m_prev = adc_data;
                    m_pv   = 1'b1;
                end
                P_CAP: if (m_kept) begin
                    m_frame.push_back(adc_data);
                    if (m_frame.size() == N_SAMPLES) m_ph = P_DONE;
                end
                default: if (vblnk && !m_vd) begin
                    for (int i = 0; i < N_SAMPLES; i++) m_disp[i] = m_frame[i];
                    m_trig = m_tq;
                    m_ph   = run ? P_ARM : P_IDLE;
                end
            endcase
            m_vd = vblnk;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (rst && chk_en) begin
            int idx;
            idx = 0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                if (data_display[i] !== m_disp[i]) begin
                    idx = i;
                    break;
                end
            end
            chk("busy", busy, (m_ph != P_IDLE));
            chk("triggered", triggered, m_trig);
            chk($sformatf("data_display[%0d]", idx), data_display[idx], m_disp[idx]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_display_first", data_display[0], 0);
        chk("reset_display_last", data_display[N_SAMPLES-1], 0);
        rst    = 1'b1;
        chk_en = 1'b1;

        // rising trigger, vblank pulses during capture must not publish
        trig_level = 12'd2048; trig_falling = 1'b0; decim = 4'd0;
        ramp = 0; step = 16; vprob = 100; gen_mode = 1;
        pulse_single();
        wait_ph(P_CAP, 400, "rise_wait_capture");
        repeat (3) begin
            vblnk = 1'b1; cycles(2);
            vblnk = 1'b0; cycles(2);
        end
        chk("tear_display_held", data_display[0], 0);
        chk("tear_busy", busy, 1);
        wait_ph(P_DONE, 400, "rise_wait_done");
        cycles(3);
        chk("done_display_held", data_display[0], 0);
        vblank_edge();
        chk("rise_disp0", data_display[0], 2048);
        chk("rise_disp1", data_display[1], 2064);
        chk("rise_disp255", data_display[255], 2032);
        chk("rise_triggered", triggered, 1);
        chk("rise_single_idle", busy, 0);

        // asynchronous reset in the middle of a capture
        ramp = 0;
        pulse_single();
        wait_ph(P_CAP, 400, "rst_wait_capture");
        cycles(10);
        #2;
        rst = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < N_SAMPLES; i++) if (data_display[i] != '0) nz++;
        chk("midrst_busy", busy, 0);
        chk("midrst_triggered", triggered, 0);
        chk("midrst_nonzero_entries", nz, 0);
        @(negedge clk);
        rst = 1'b1;

        // falling trigger on a descending ramp
        trig_falling = 1'b1; trig_level = 12'd1000;
        ramp = 4080; step = 4080;
        pulse_single();
        wait_ph(P_DONE, 800, "fall_wait_done");
        vblank_edge();
        chk("fall_disp0", data_display[0], 992);
        chk("fall_disp1", data_display[1], 976);
        chk("fall_disp255", data_display[255], 1008);
        chk("fall_triggered", triggered, 1);

        // decimation by 4 on a +1 ramp
        trig_falling = 1'b0; trig_level = 12'd10; decim = 4'd3;
        gen_mode = 0; ramp = 1; step = 1;
        pulse_single();
        wait_ph(P_WAIT, 10, "decim_wait_arm");
        gen_mode = 1;
        wait_ph(P_DONE, 2000, "decim_wait_done");
        vblank_edge();
        chk("decim_disp0", data_display[0], 12);
        chk("decim_disp1", data_display[1], 16);
        chk("decim_disp2", data_display[2], 20);
        chk("decim_disp255", data_display[255], 1032);

        // auto trigger on a flat signal with continuous re-arm, then run dropped
        decim = 4'd0; trig_level = 12'd2048; cval = 100; gen_mode = 2; run = 1'b1;
        wait_ph(P_DONE, 1000, "auto_wait_done");
        cycles(2);
        vblank_edge();
        chk("auto_disp0", data_display[0], 100);
        chk("auto_disp255", data_display[255], 100);
        chk("auto_triggered", triggered, 0);
        chk("auto_rearmed", busy, 1);
        wait_ph(P_CAP, 1000, "auto_wait_capture2");
        run = 1'b0;
        wait_ph(P_DONE, 600, "auto_wait_done2");
        vblank_edge();
        chk("run_drop_idle", busy, 0);

        // randomized traffic with free-running vblank
        vb_auto = 1'b1;
        for (int it = 0; it < 6; it++) begin
            decim        = DECIM_W'($urandom_range(2));
            trig_level   = DATA_W'($urandom_range(4095));
            trig_falling = 1'($urandom_range(1));
            vprob        = int'($urandom_range(100, 50));
            cval         = int'($urandom_range(4095));
            gen_mode     = (it % 3 == 2) ? 2 : 3;
            run          = 1'($urandom_range(1));
            for (int c = 0; c < 1500; c++) begin
                single = ($urandom_range(199) == 0);
                @(negedge clk);
            end
            single = 1'b0;
        end
        run = 1'b0;
        wait_ph(P_IDLE, 6000, "random_wait_idle");
        cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
